// File: rtl/seg7_pkg.sv
// Shared types and sizes for the seven-segment shift-register scanner.
package seg7_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DWELL
  } state_t;

  localparam int SHIFT_BITS = 16;
  localparam int NUM_DIGITS = 4;

endpackage

// File: rtl/seg7_phase_timer.sv
// Loadable down-counter; done is high for one cycle, the last cycle of a loaded interval.
module seg7_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Loading N yields N cycles with done in the last one; it then parks at zero.
  assign done = (cnt == W'(1));

endmodule

// File: rtl/seg7_shift_scanner.sv
// Round-robin digit scanner feeding two daisy-chained 595 registers, one latch per digit.
//   state    | meaning
//   ST_IDLE  | waiting for enable_i
//   ST_LOAD  | capture decoder word for digit_o
//   ST_SHIFT | 16 serial bits out, MSB first
//   ST_LATCH | rclk_o high for CLK_DIV cycles
//   ST_DWELL | hold latched digit for DWELL cycles
module seg7_shift_scanner
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DWELL   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [15:0] data_i,
  output logic [1:0]  digit_o,
  output logic        ser_o,
  output logic        srclk_o,
  output logic        rclk_o,
  output logic        busy_o,
  output logic        frame_o
);

  localparam int TMR_MAX = (CLK_DIV > DWELL) ? CLK_DIV : DWELL;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] DIV_LD   = TMR_W'(CLK_DIV);
  localparam logic [TMR_W-1:0] DWELL_LD = TMR_W'(DWELL);
  localparam logic [4:0]       LAST_BIT   = 5'(SHIFT_BITS - 1);
  localparam logic [1:0]       LAST_DIGIT = 2'(NUM_DIGITS - 1);

  state_t                state, state_d;
  logic [SHIFT_BITS-1:0] shreg, shreg_d;
  logic [4:0]            bit_cnt, bit_cnt_d;
  logic [1:0]            digit_q, digit_d;
  logic                  ser_q, ser_d;
  logic                  srclk_q, srclk_d;
  logic                  rclk_q, rclk_d;
  logic                  busy_q, busy_d;
  logic                  frame_q, frame_d;
  logic                  tmr_load;
  logic [TMR_W-1:0]      tmr_val;
  logic                  tmr_done;

  seg7_phase_timer #(.W(TMR_W)) u_timer (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      digit_q <= '0;
      ser_q   <= 1'b0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      digit_q <= digit_d;
      ser_q   <= ser_d;
      srclk_q <= srclk_d;
      rclk_q  <= rclk_d;
      busy_q  <= busy_d;
      frame_q <= frame_d;
    end
  end

  // All outputs are registered copies of next-cycle values, so they line up with state.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    digit_d   = digit_q;
    ser_d     = ser_q;
    srclk_d   = srclk_q;
    rclk_d    = rclk_q;
    frame_d   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = DIV_LD;

    case (state)
      ST_IDLE: begin
        if (enable_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_d   = data_i;
        ser_d     = data_i[SHIFT_BITS-1];
        srclk_d   = 1'b0;
        bit_cnt_d = '0;
        tmr_load  = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (!srclk_q) begin
            srclk_d = 1'b1;
          end else begin
            srclk_d   = 1'b0;
            bit_cnt_d = bit_cnt + 5'd1;
            if (bit_cnt == LAST_BIT) begin
              rclk_d  = 1'b1;
              state_d = ST_LATCH;
            end else begin
              // Next bit appears only as the low phase begins.
              shreg_d = {shreg[SHIFT_BITS-2:0], 1'b0};
              ser_d   = shreg[SHIFT_BITS-2];
            end
          end
        end
      end
      ST_LATCH: begin
        if (tmr_done) begin
          rclk_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = DWELL_LD;
          state_d  = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (tmr_done) begin
          digit_d = (digit_q == LAST_DIGIT) ? 2'd0 : digit_q + 2'd1;
          frame_d = (digit_q == LAST_DIGIT);
          state_d = enable_i ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign digit_o = digit_q;
  assign ser_o   = ser_q;
  assign srclk_o = srclk_q;
  assign rclk_o  = rclk_q;
  assign busy_o  = busy_q;
  assign frame_o = frame_q;

endmodule

// File: doc/seg7_shift_scanner.md
# seg7_shift_scanner

Sequential driver that sits downstream of the 4-digit seven-segment decoder. It scans digits 0..3 round-robin and presents the current index to the decoder. For each digit it captures the decoder's 16-bit shift-register word and shifts it out MSB-first to two daisy-chained 74HC595-style registers, then pulses the storage latch and holds the digit for a fixed dwell time. Only the latch pulse changes the display, so segment and anode bits always update together.

## Interface
- CLK_DIV, 2: cycles per serial-clock half-period; also the latch-pulse width. Must be ≥1.
- DWELL, 8: cycles a latched digit is held before the next digit starts. Must be ≥1.

- clk_i  input  1  system clock
- rst_i  input  1  reset, synchronous and active-high
- enable_i  input  1  run scanning; sampled at the start of each digit only
- data_i  input  16  shift word from decoder for the digit on digit_o
- digit_o  output  2  digit index to decoder
- ser_o  output  1  serial data to 595 SER
- srclk_o  output  1  595 shift clock
- rclk_o  output  1  595 storage latch clock
- busy_o  output  1  high in every state except IDLE
- frame_o  output  1  one-cycle pulse when digit_o wraps 3→0

## Operation
- States:
  - IDLE: waits for enable_i.
  - LOAD: captures data_i.
  - SHIFT: shifts out 16 bits.
  - LATCH: drives rclk_o high.
  - DWELL: holds the latched digit.
- IDLE → LOAD when enable_i=1.
- LOAD lasts one cycle.
  - Registers data_i into a 16-bit shift register.
  - Drives ser_o = data_i[15] and srclk_o = 0.
- SHIFT: 16 bits, bit 15 first.
  - Each bit: srclk_o low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - ser_o changes only on entry to a low phase, so it is stable around each rising edge.
  - A 5-bit bit counter ends SHIFT after the 16th high phase.
- LATCH: srclk_o=0 and rclk_o=1 for CLK_DIV cycles.
- DWELL: srclk_o=0 and rclk_o=0 for DWELL cycles.
- On DWELL exit:
  - digit_o increments modulo 4.
  - frame_o pulses if the increment wraps 3→0.
  - Next state is LOAD if enable_i=1, else IDLE.
- data_i is ignored outside LOAD. Changes during SHIFT do not affect bits already being shifted.
- enable_i deasserted mid-digit: the digit completes SHIFT, LATCH and DWELL normally. The block then enters IDLE with digit_o already advanced.

## Timing
- Reset values (one edge after rst_i=1): digit_o=0, ser_o=0, srclk_o=0, rclk_o=0, busy_o=0, frame_o=0, state=IDLE.
- Reset mid-operation:
  - The partial shift is abandoned and no rclk_o pulse is issued.
  - The external latch keeps the previous digit.
  - Reset overrides enable_i and all state.
- enable_i=1 in IDLE gives LOAD on the next cycle.
- The decoder sees a new digit_o at least one full cycle before LOAD samples data_i.
- Digit period = 1 + 32·CLK_DIV + CLK_DIV + DWELL cycles. With defaults: 1 + 64 + 2 + 8 = 75 cycles.
- frame_o rises in the same cycle digit_o becomes 0 and is high for exactly one cycle.
- busy_o is high from LOAD through DWELL inclusive.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package seg7_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, LATCH, DWELL);
  - SHIFT_BITS=16;
  - NUM_DIGITS=4.
- Sub-module seg7_phase_timer: a loadable down-counter that produces a one-cycle "done" strobe.
  - Sized with $clog2 of max(CLK_DIV, DWELL) + 1.
  - Reused for half-periods, the latch pulse and the dwell.
- The top module holds the FSM, shift register, bit counter and digit counter.

## Test plan
All scenarios use the defaults (CLK_DIV=2, DWELL=8).
- Reset: hold rst_i=1 for 3 cycles with enable_i=1 → all outputs 0 and busy_o=0 one edge after assertion.
- Shift pattern: data_i=16'hA5C3, enable_i=1 → ser_o sampled at the 16 srclk_o rising edges reads 1010_0101_1100_0011; rclk_o high for 2 cycles after the 16th rising edge; digit period 75 cycles.
- Scan order: enable_i held at 1 → digit_o sequence 0,1,2,3,0 with each digit period 75 cycles; frame_o is a single pulse coinciding with the 3→0 wrap, every 300 cycles.
- Enable drop: deassert enable_i during SHIFT of digit 1 → digit 1 latches normally, then IDLE with digit_o=2 and busy_o=0; reassert → LOAD the next cycle.
- Reset mid-shift: assert rst_i after the 7th srclk_o rising edge → next cycle digit_o=0, all outputs 0, no rclk_o pulse.
- Input isolation: data_i toggles between 16'hFFFF and 16'h0000 every cycle after LOAD captured 16'h1234 → shifted stream is exactly 16'h1234.
